// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: struct_pckg payload type plus data-memory port (master drives req/we/addr/wdata/be, slave drives gnt/rvalid/rdata)
package struct_pckg;
  typedef struct packed {
    logic        is_valid;
    logic [4:0]  rd_addr;
    logic        rf_wr;
    logic [63:0] rf_wr_data;
    logic        mem_rd;
    logic        mem_wr;
    logic [3:0]  mem_req_unit;
    logic        mem_ext;
    logic        mem_to_reg;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic        en_sign_ext;
    logic        branch_taken;
    logic [63:0] branch_target;
  } interconnection_struct;
endpackage

interface mem_access_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_be_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;
  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage; ex_in in, wb_out out, dmem master port, mem_stall_o/misaligned_o/timeout_o flags
module mem_access_stage
  import struct_pckg::*;
#(
  parameter int XLEN     = 64,
  parameter int MAX_WAIT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  interconnection_struct ex_in,
  mem_access_stage_if.master    dmem,
  output interconnection_struct wb_out,
  output logic                  mem_stall_o,
  output logic                  misaligned_o,
  output logic                  timeout_o
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
  state_t                state_q;
  interconnection_struct pay_q, wb_q;
  logic [CW-1:0]         cnt_q;
  logic                  req_q, we_q, mis_q, tmo_q;
  logic [XLEN-1:0]       addr_q, wdata_q, sh, ld_res;
  logic [7:0]            be_q, in_mask;
  logic [3:0]            u, in_u;
  logic [2:0]            in_off, off;
  logic                  in_mem, in_mis, e;
  assign in_u    = ex_in.mem_req_unit;
  assign in_off  = ex_in.mem_addr[2:0];
  assign in_mem  = ex_in.is_valid & (ex_in.mem_rd | ex_in.mem_wr);
  assign in_mis  = (in_u[1] & in_off[0]) | (in_u[2] & |in_off[1:0]) | (in_u[3] & |in_off);
  assign in_mask = in_u[0] ? 8'h01 : in_u[1] ? 8'h03 : in_u[2] ? 8'h0F : 8'hFF;
  assign u       = pay_q.mem_req_unit;
  assign e       = pay_q.mem_ext;
  assign off     = pay_q.mem_addr[2:0];
  assign sh      = dmem.dmem_rdata_i >> {off, 3'b000};
  assign ld_res  = u[0] ? {{56{e & sh[7]}}, sh[7:0]} :
                   u[1] ? {{48{e & sh[15]}}, sh[15:0]} :
                   u[2] ? {{32{e & sh[31]}}, sh[31:0]} : sh;
  assign mem_stall_o       = (state_q == REQ) | (state_q == WAIT_RSP) | ((state_q == IDLE) & in_mem & ~in_mis);
  assign dmem.dmem_req_o   = req_q;
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_wdata_o = wdata_q;
  assign dmem.dmem_be_o    = be_q;
  assign wb_out            = wb_q;
  assign misaligned_o      = mis_q;
  assign timeout_o         = tmo_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pay_q   <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      tmo_q <= 1'b0;
      case (state_q)
        IDLE:
          if (in_mem && in_mis) begin
            wb_q       <= ex_in;
            wb_q.rf_wr <= 1'b0;
            mis_q      <= 1'b1;
          end else if (in_mem) begin
            wb_q.is_valid <= 1'b0;
            pay_q   <= ex_in;
            req_q   <= 1'b1;
            we_q    <= ex_in.mem_wr;
            addr_q  <= {ex_in.mem_addr[XLEN-1:3], 3'b000};
            wdata_q <= ex_in.mem_wr ? ex_in.mem_data << {in_off, 3'b000} : '0;
            be_q    <= in_mask << in_off;
            state_q <= REQ;
          end else if (ex_in.is_valid) wb_q <= ex_in;
          else wb_q.is_valid <= 1'b0;
        REQ: begin
          wb_q.is_valid <= 1'b0;
          if (dmem.dmem_gnt_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            state_q <= we_q ? DONE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          wb_q.is_valid <= 1'b0;
          cnt_q <= cnt_q + 1'b1;
          if (dmem.dmem_rvalid_i) begin
            if (pay_q.mem_to_reg) pay_q.rf_wr_data <= ld_res;
            state_q <= DONE;
          end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
            pay_q.rf_wr <= 1'b0;
            tmo_q       <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          wb_q    <= pay_q;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table-driven and directed-sequence checks of mem_access_stage
module tb_mem_access_stage;
  import struct_pckg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  interconnection_struct ex_in, wb_out, exp_s;
  logic mem_stall_o, misaligned_o, timeout_o;
  int tests = 0;
  int fails = 0;
  mem_access_stage_if dif ();
  mem_access_stage dut (
    .clk(clk), .rst(rst), .ex_in(ex_in), .dmem(dif), .wb_out(wb_out),
    .mem_stall_o(mem_stall_o), .misaligned_o(misaligned_o), .timeout_o(timeout_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    interconnection_struct in;
    logic e_vld, e_rfw, e_mis, chk_all;
  } vec_t;
  vec_t tbl[7];
  function automatic interconnection_struct mk(logic rd, logic wr, logic [3:0] unit, logic ext,
                                               logic [63:0] addr, logic [63:0] data, logic rfw, logic [63:0] rfd);
    interconnection_struct s = '0;
    s.is_valid = 1'b1;
    s.rd_addr = 5'd7;
    s.rf_wr = rfw;
    s.rf_wr_data = rfd;
    s.mem_rd = rd;
    s.mem_wr = wr;
    s.mem_req_unit = unit;
    s.mem_ext = ext;
    s.mem_to_reg = rd;
    s.mem_addr = addr;
    s.mem_data = data;
    s.en_sign_ext = 1'b1;
    s.branch_taken = 1'b1;
    s.branch_target = 64'hCAFE_0000_0000_BEEF;
    return s;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load_seq(input string nm, input logic [63:0] addr, input logic [3:0] unit, input logic ext,
                          input logic [7:0] be, input logic [63:0] rdata, input logic [63:0] exp);
    ex_in = mk(1'b1, 1'b0, unit, ext, addr, 64'h0, 1'b1, 64'h5555);
    #1 chk({nm, "_stall_idle"}, mem_stall_o, 1);
    tick;
    ex_in = '0;
    chk({nm, "_req"}, dif.dmem_req_o, 1);
    chk({nm, "_addr"}, dif.dmem_addr_o, {addr[63:3], 3'b000});
    chk({nm, "_be"}, dif.dmem_be_o, be);
    chk({nm, "_we"}, dif.dmem_we_o, 0);
    chk({nm, "_wdata"}, dif.dmem_wdata_o, 0);
    dif.dmem_gnt_i = 1'b1;
    dif.dmem_rvalid_i = 1'b1;
    dif.dmem_rdata_i = ~rdata;
    tick;
    dif.dmem_gnt_i = 1'b0;
    dif.dmem_rvalid_i = 1'b0;
    chk({nm, "_req_drop"}, dif.dmem_req_o, 0);
    chk({nm, "_bubble"}, wb_out.is_valid, 0);
    #1 chk({nm, "_stall_wait"}, mem_stall_o, 1);
    tick;
    dif.dmem_rvalid_i = 1'b1;
    dif.dmem_rdata_i = rdata;
    tick;
    dif.dmem_rvalid_i = 1'b0;
    #1 chk({nm, "_stall_done"}, mem_stall_o, 0);
    tick;
    chk({nm, "_wb_valid"}, wb_out.is_valid, 1);
    chk({nm, "_wb_rfwr"}, wb_out.rf_wr, 1);
    chk({nm, "_wb_data"}, wb_out.rf_wr_data, exp);
  endtask
  initial begin
    int n;
    ex_in = '0;
    dif.dmem_gnt_i = 1'b0;
    dif.dmem_rvalid_i = 1'b0;
    dif.dmem_rdata_i = '0;
    tbl[0] = '{mk(0, 0, 4'b0000, 0, 64'h0, 64'h0, 1, 64'h1234), 1, 1, 0, 1};
    tbl[1] = '{interconnection_struct'('0), 0, 0, 0, 0};
    tbl[2] = '{mk(1, 0, 4'b0100, 0, 64'h2002, 64'h0, 1, 64'h55), 1, 0, 1, 1};
    tbl[3] = '{mk(0, 1, 4'b0010, 0, 64'h11, 64'hAA, 0, 64'h66), 1, 0, 1, 1};
    tbl[4] = '{mk(1, 0, 4'b1000, 1, 64'h4, 64'h0, 1, 64'h77), 1, 0, 1, 1};
    tbl[5] = '{mk(1, 0, 4'b0100, 1, 64'h3001, 64'h0, 1, 64'h88), 1, 0, 1, 1};
    tbl[6] = '{mk(0, 0, 4'b0000, 0, 64'h0, 64'h0, 0, 64'hDEAD), 1, 0, 0, 1};
    tick;
    tick;
    chk("rst_wb_valid", wb_out.is_valid, 0);
    chk("rst_wb_data", wb_out.rf_wr_data, 0);
    chk("rst_req", dif.dmem_req_o, 0);
    chk("rst_we", dif.dmem_we_o, 0);
    chk("rst_addr", dif.dmem_addr_o, 0);
    chk("rst_wdata", dif.dmem_wdata_o, 0);
    chk("rst_be", dif.dmem_be_o, 0);
    chk("rst_stall", mem_stall_o, 0);
    chk("rst_mis", misaligned_o, 0);
    chk("rst_tmo", timeout_o, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ex_in = tbl[i].in;
      #1 chk($sformatf("tbl%0d_stall", i), mem_stall_o, 0);
      tick;
      chk($sformatf("tbl%0d_valid", i), wb_out.is_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_mis", i), misaligned_o, tbl[i].e_mis);
      chk($sformatf("tbl%0d_req", i), dif.dmem_req_o, 0);
      if (tbl[i].chk_all) begin
        exp_s = tbl[i].in;
        exp_s.rf_wr = tbl[i].e_rfw;
        tests++;
        if (wb_out !== exp_s) begin
          fails++;
          $display("FAIL tbl%0d_wb: got %h expected %h", i, wb_out, exp_s);
        end
      end
    end
    ex_in = mk(0, 1, 4'b0001, 0, 64'h1003, 64'hAB, 0, 64'h0);
    #1 chk("st_stall_idle", mem_stall_o, 1);
    chk("st_req_idle", dif.dmem_req_o, 0);
    for (int r = 0; r < 3; r++) begin
      tick;
      ex_in = '0;
      dif.dmem_gnt_i = (r == 2);
      chk($sformatf("st_req%0d", r), dif.dmem_req_o, 1);
      chk($sformatf("st_addr%0d", r), dif.dmem_addr_o, 64'h1000);
      chk($sformatf("st_be%0d", r), dif.dmem_be_o, 8'h08);
      chk($sformatf("st_wdata%0d", r), dif.dmem_wdata_o, 64'hAB00_0000);
      chk($sformatf("st_we%0d", r), dif.dmem_we_o, 1);
      chk($sformatf("st_bubble%0d", r), wb_out.is_valid, 0);
      #1 chk($sformatf("st_stall%0d", r), mem_stall_o, 1);
    end
    tick;
    dif.dmem_gnt_i = 1'b0;
    chk("st_req_done", dif.dmem_req_o, 0);
    chk("st_bubble_done", wb_out.is_valid, 0);
    #1 chk("st_stall_done", mem_stall_o, 0);
    tick;
    chk("st_wb_valid", wb_out.is_valid, 1);
    chk("st_wb_rfwr", wb_out.rf_wr, 0);
    chk("st_wb_addr", wb_out.mem_addr, 64'h1003);
    load_seq("ldh_s", 64'h2006, 4'b0010, 1'b1, 8'hC0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    load_seq("ldh_u", 64'h2006, 4'b0010, 1'b0, 8'hC0, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);
    load_seq("ldb_s", 64'h2005, 4'b0001, 1'b1, 8'h20, 64'h0000_9A00_0000_0000, 64'hFFFF_FFFF_FFFF_FF9A);
    load_seq("ldw_u", 64'h2004, 4'b0100, 1'b0, 8'hF0, 64'hF234_5678_0000_0000, 64'h0000_0000_F234_5678);
    load_seq("ldd", 64'h2008, 4'b1000, 1'b1, 8'hFF, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF);
    ex_in = mk(1, 0, 4'b1000, 0, 64'h3000, 64'h0, 1, 64'h99);
    tick;
    ex_in = '0;
    dif.dmem_gnt_i = 1'b1;
    tick;
    dif.dmem_gnt_i = 1'b0;
    n = 0;
    while (!timeout_o && n < 400) begin
      tick;
      n++;
    end
    chk("tmo_cycles", n, 255);
    chk("tmo_pulse", timeout_o, 1);
    #1 chk("tmo_stall", mem_stall_o, 0);
    tick;
    chk("tmo_pulse_end", timeout_o, 0);
    chk("tmo_wb_valid", wb_out.is_valid, 1);
    chk("tmo_wb_rfwr", wb_out.rf_wr, 0);
    chk("tmo_wb_data", wb_out.rf_wr_data, 64'h99);
    ex_in = mk(0, 0, 4'b0000, 0, 64'h0, 64'h0, 1, 64'hBEEF);
    tick;
    chk("tmo_next_data", wb_out.rf_wr_data, 64'hBEEF);
    chk("tmo_next_valid", wb_out.is_valid, 1);
    ex_in = mk(1, 0, 4'b0001, 0, 64'h2000, 64'h0, 1, 64'h1);
    tick;
    ex_in = '0;
    chk("rreq_req", dif.dmem_req_o, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rreq_req_drop", dif.dmem_req_o, 0);
    ex_in = mk(1, 0, 4'b0001, 0, 64'h2000, 64'h0, 1, 64'h1);
    tick;
    ex_in = '0;
    dif.dmem_gnt_i = 1'b1;
    tick;
    dif.dmem_gnt_i = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rwait_req", dif.dmem_req_o, 0);
    chk("rwait_wb_valid", wb_out.is_valid, 0);
    #1 chk("rwait_stall", mem_stall_o, 0);
    dif.dmem_rvalid_i = 1'b1;
    dif.dmem_rdata_i = 64'h42;
    tick;
    dif.dmem_rvalid_i = 1'b0;
    chk("rwait_late_valid", wb_out.is_valid, 0);
    chk("rwait_late_req", dif.dmem_req_o, 0);
    #1 chk("rwait_late_stall", mem_stall_o, 0);
    tick;
    chk("rwait_late_valid2", wb_out.is_valid, 0);
    ex_in = mk(0, 0, 4'b0000, 0, 64'h0, 64'h0, 1, 64'h777);
    tick;
    chk("rwait_next_data", wb_out.rf_wr_data, 64'h777);
    chk("rwait_next_valid", wb_out.is_valid, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage between the EX/MEM and MEM/WB registers.
- Consumes the EX-produced interconnection_struct from struct_pckg and drives a req/gnt/rvalid data-memory port.
- Aligns store data and byte enables; aligns, sign- or zero-extends load data.
- Emits a registered interconnection_struct to WB and stalls upstream while a memory transaction is outstanding.

Parameters:
- XLEN, 64, datapath width (fixed; only 64 supported)
- MAX_WAIT, 255, response-wait cycles before timeout error

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_in  in  interconnection_struct  EX-stage payload; valid when ex_in.is_valid=1
- mem_stall_o  out  1  freeze EX and earlier stages
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1=store, 0=load
- dmem_addr_o  out  64  dword-aligned address {mem_addr[63:3],3'b000}
- dmem_wdata_o  out  64  lane-shifted store data
- dmem_be_o  out  8  byte enables
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  64  load data
- wb_out  out  interconnection_struct  registered payload to WB
- misaligned_o  out  1  one-cycle pulse on misaligned access
- timeout_o  out  1  one-cycle pulse on response timeout

Behaviour:
- Reset values: state=IDLE; wb_out all-zero (is_valid=0); all dmem_* outputs 0; mem_stall_o, misaligned_o, timeout_o 0; wait counter 0.
- Access width: mem_req_unit is one-hot: 0001=byte, 0010=half, 0100=word, 1000=dword. mem_ext=1 sign-extends, 0 zero-extends. off=mem_addr[2:0].
- Misaligned cases:
  - half with off[0]=1
  - word with off[1:0]!=0
  - dword with off!=0
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - No-memory op (is_valid=1, mem_rd=0, mem_wr=0): wb_out<=ex_in next edge (1-cycle latency), no stall.
  - is_valid=0: wb_out.is_valid<=0 (bubble).
  - Valid mem op, aligned: latch ex_in, mem_stall_o=1 combinationally this cycle, go REQ.
  - Valid mem op, misaligned: no request; wb_out<=ex_in with rf_wr=0; misaligned_o=1 next cycle; stay IDLE.
- REQ:
  - dmem_req_o=1; addr/we/wdata/be held stable until gnt.
  - Store: wdata=mem_data<<(8*off), be=unit_mask<<off. Unit masks: 01, 03, 0F, FF.
  - Load: be=unit_mask<<off, wdata=0.
  - On gnt: store -> DONE; load -> WAIT_RSP, clear counter.
- WAIT_RSP:
  - dmem_req_o=0.
  - On rvalid: shifted=rdata>>(8*off), truncate to unit, extend per mem_ext; rf_wr_data<=result; -> DONE.
  - rvalid in the same cycle as gnt is not accepted; response is expected at least 1 cycle after gnt.
  - Counter increments each cycle. If it reaches MAX_WAIT: timeout_o pulse; payload forwarded with rf_wr=0; -> DONE.
- DONE:
  - wb_out<=latched payload (load result inserted when mem_to_reg=1).
  - mem_stall_o=0 this cycle; -> IDLE.
  - ex_in presented in DONE is not consumed. Upstream holds it because stall was high the previous cycle; it is processed in IDLE next cycle.
- mem_stall_o=1 in REQ and WAIT_RSP, and in IDLE when a valid aligned mem op is present.
- While stalled, wb_out.is_valid=0 every cycle (bubbles to WB).
- Minimum latencies: store 3 cycles (IDLE->REQ->DONE with gnt in first REQ cycle); load 4 cycles plus response delay.
- rst mid-transaction: next edge forces IDLE and deasserts req. Outstanding response is discarded; an rvalid after reset while in IDLE is ignored.
- en_sign_ext, branch fields and the rest of the struct pass through unchanged.

Test Plan:
- ALU op (rf_wr=1, rf_wr_data=0x1234, no mem) -> wb_out identical next cycle, mem_stall_o never high.
- Store byte mem_addr=0x1003, mem_data=0xAB -> dmem_addr_o=0x1000, be=0x08, wdata=0xAB000000; gnt after 2 cycles: req held 3 cycles with stable fields, wb_out.is_valid one cycle after gnt.
- Load half signed addr=0x2006, rdata=0x8001_0000_0000_0000 -> rf_wr_data=0xFFFF_FFFF_FFFF_8001; unsigned variant -> 0x0000_0000_0000_8001.
- Load word addr=0x2002 -> no dmem_req_o, misaligned_o pulse, wb_out.rf_wr=0.
- Load with no rvalid for MAX_WAIT cycles -> timeout_o pulse, wb_out.rf_wr=0, FSM back to IDLE, next op proceeds.
- rst asserted in WAIT_RSP, late rvalid delivered after reset -> req low after one edge, wb_out.is_valid=0, rvalid ignored.
